branch_predict_ctrl: RTL and testbench
======================================

// Module: branch_predict_ctrl
// PURPOSE
//   Dynamic branch predictor and resolution controller wrapped around the ID-stage branch comparator.
//   - Predicts taken/not-taken for the fetch PC from a table of 2-bit saturating counters.
//   - Resolves each ID-stage branch using the comparator result.
//   - Raises a mispredict flush to the fetch logic.
//   - Trains the table one cycle after resolution and keeps branch and mispredict statistics.
// PARAMETERS
//   IDX_BITS   6    table index width; table has 2**IDX_BITS entries
//   CNT_BITS   16   width of each statistics counter
// PORTS
//   clk            in   1         rising-edge clock
//   rst_n          in   1         asynchronous reset, active low
//   if_pc          in   32        fetch-stage PC to predict
//   pred_taken     out  1         prediction for if_pc (counter MSB)
//   id_valid       in   1         ID stage holds a valid instruction
//   id_is_branch   in   1         ID instruction is a conditional branch (Branch code != 0)
//   id_stall       in   1         ID frozen; comparator operands not yet forwarded
//   id_pc          in   32        PC of the ID instruction
//   id_pred_taken  in   1         prediction carried down the pipe with the instruction
//   cmp_result     in   1         comparator output for the ID instruction
//   mispredict     out  1         flush IF and redirect to the correct path
//   clr_stats      in   1         synchronous clear of the statistics counters
//   branch_cnt     out  CNT_BITS  resolved branches since reset or clear
//   mispred_cnt    out  CNT_BITS  mispredicted branches since reset or clear
// BEHAVIOUR
//   - Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
//   - Reset values:
//     - Every table entry = 2'b01 (weakly not-taken).
//     - Update register invalid.
//     - branch_cnt = mispred_cnt = 0; mispredict = 0; pred_taken = 0.
//   - Index: idx(pc) = pc[IDX_BITS+1:2]; the word-aligned PC bits [1:0] are ignored.
//   - Lookup is combinational: pred_taken = eff[idx(if_pc)][1].
//     - eff is the table entry, unless the update register is valid with the same index.
//     - In that case eff is the new counter value being written this cycle (bypass).
//   - A branch resolves when res = id_valid & id_is_branch & ~id_stall.
//     - While id_stall = 1, no resolution, no update, no count.
//     - The ID instruction resolves exactly once, in the cycle the stall drops.
//   - mispredict = res & (cmp_result != id_pred_taken). Combinational, zero latency, one cycle per resolution.
//   - Update register: at each edge with res = 1, latch {valid = 1, idx(id_pc), cmp_result}; otherwise valid <= 0.
//   - Table write: at the edge after resolution, entry[upd_idx] <= sat(entry, upd_taken).
//     - Taken: +1, saturating at 2'b11.
//     - Not taken: -1, saturating at 2'b00.
//   - Back-to-back resolutions to the same index chain correctly.
//     - The second read uses the bypassed value, not the stale entry.
//   - Statistics:
//     - On res: branch_cnt += 1.
//     - On mispredict: mispred_cnt += 1.
//     - Both saturate at all-ones and never wrap.
//     - clr_stats wins over a simultaneous increment: the result is 0, not 1.
//   - Reset mid-operation: table, update register and counters return to reset values immediately.
//     - A pending update is discarded.
//     - mispredict drops while rst_n = 0.
//   - No X propagation: unknown id_* with id_valid = 0 has no effect.
// TESTING
//   1. Reset, then if_pc = 0x0000_3000 -> pred_taken = 0; all 64 entries read 2'b01; both counters 0.
//   2. Branch at 0x3004, id_pred_taken = 0, cmp_result = 1
//      -> mispredict = 1 that cycle, entry[1] = 2'b10 after next edge,
//         pred_taken = 1 for if_pc = 0x3004, branch_cnt = 1, mispred_cnt = 1.
//   3. Same branch resolved taken on 3 consecutive cycles
//      -> entry[1] goes 01 -> 10 -> 11 -> 11 (saturates);
//         bypass makes pred_taken = 1 in the write cycle.
//   4. id_stall = 1 for 4 cycles with a valid branch
//      -> no mispredict pulse, counters unchanged;
//         the stall-drop cycle produces exactly one resolution.
//   5. mispred_cnt preloaded to 0xFFFF plus one mispredict -> stays 0xFFFF;
//      clr_stats with a simultaneous resolution -> both counters 0.
//   6. rst_n low for one cycle during a pending update to 0x3010 -> entry[4] stays 2'b01.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor with a table of 2-bit saturating counters.
// It resolves ID-stage branches, flags mispredicts, trains the table and keeps statistics.
module branch_predict_ctrl #(
    parameter int IDX_BITS = 6,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         if_pc,
    output logic                pred_taken,
    input  logic                id_valid,
    input  logic                id_is_branch,
    input  logic                id_stall,
    input  logic [31:0]         id_pc,
    input  logic                id_pred_taken,
    input  logic                cmp_result,
    output logic                mispredict,
    input  logic                clr_stats,
    output logic [CNT_BITS-1:0] branch_cnt,
    output logic [CNT_BITS-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          counters [ENTRIES];
    logic                upd_valid;
    logic [IDX_BITS-1:0] upd_idx;
    logic                upd_taken;
    logic [1:0]          upd_new;
    logic [IDX_BITS-1:0] if_idx;
    logic [1:0]          eff;
    logic                res;
    logic                unused_pc_bits;

    function automatic logic [1:0] sat(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

    assign if_idx  = if_pc[IDX_BITS+1:2];
    assign upd_new = sat(counters[upd_idx], upd_taken);

    // The entry being written this cycle is forwarded so fetch sees the trained value at once.
    assign eff        = (upd_valid && (upd_idx == if_idx)) ? upd_new : counters[if_idx];
    assign pred_taken = eff[1];

    assign res        = id_valid & id_is_branch & ~id_stall;
    assign mispredict = rst_n & res & (cmp_result ^ id_pred_taken);

    assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0],
                              id_pc[31:IDX_BITS+2], id_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            upd_taken <= 1'b0;
        end else begin
            upd_valid <= res;
            if (res) begin
                upd_idx   <= id_pc[IDX_BITS+1:2];
                upd_taken <= cmp_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                counters[i] <= 2'b01;
        end else if (upd_valid) begin
            counters[upd_idx] <= upd_new;
        end
    end

    // A clear takes priority over any increment landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (clr_stats) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (res && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_BITS'(1);
            if (mispredict && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with hand-computed expectations.
// Counters are narrowed to 8 bits so that saturation is reached in a few hundred cycles.
module tb_branch_predict_ctrl;

    localparam int IDX_BITS = 6;
    localparam int CNT_BITS = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [31:0]         if_pc;
    logic                pred_taken;
    logic                id_valid;
    logic                id_is_branch;
    logic                id_stall;
    logic [31:0]         id_pc;
    logic                id_pred_taken;
    logic                cmp_result;
    logic                mispredict;
    logic                clr_stats;
    logic [CNT_BITS-1:0] branch_cnt;
    logic [CNT_BITS-1:0] mispred_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl #(.IDX_BITS(IDX_BITS), .CNT_BITS(CNT_BITS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .id_valid      (id_valid),
        .id_is_branch  (id_is_branch),
        .id_stall      (id_stall),
        .id_pc         (id_pc),
        .id_pred_taken (id_pred_taken),
        .cmp_result    (cmp_result),
        .mispredict    (mispredict),
        .clr_stats     (clr_stats),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic br, input logic st,
                                 input logic [31:0] pc, input logic pt, input logic cmp);
        id_valid      = v;
        id_is_branch  = br;
        id_stall      = st;
        id_pc         = pc;
        id_pred_taken = pt;
        id_cmp_set(cmp);
    endtask

    task automatic id_cmp_set(input logic cmp);
        cmp_result = cmp;
    endtask

    // Idle drives unknowns on the ID operands to show they are ignored without id_valid.
    task automatic idle();
        id_valid      = 1'b0;
        id_is_branch  = 1'bx;
        id_stall      = 1'bx;
        id_pc         = 'x;
        id_pred_taken = 1'bx;
        cmp_result    = 1'bx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        clr_stats = 1'b0;
        if_pc     = 32'h0000_3000;
        idle();
        #3;
        checkOutput("rst_mispredict", {31'b0, mispredict}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: reset state
        #2;
        checkOutput("t1_pred", {31'b0, pred_taken}, 32'd0);
        checkOutput("t1_branch_cnt", 32'(branch_cnt), 32'd0);
        checkOutput("t1_mispred_cnt", 32'(mispred_cnt), 32'd0);
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'h0000_3000 + 32'(i * 4);
            #0.1;
            checkOutput($sformatf("t1_entry%0d", i), {31'b0, pred_taken}, 32'd0);
        end
        tick();

        // 2: first mispredicted taken branch at 0x3004
        if_pc = 32'h0000_3004;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3004, 1'b0, 1'b1);
        #2;
        checkOutput("t2_mispredict", {31'b0, mispredict}, 32'd1);
        checkOutput("t2_pred_before", {31'b0, pred_taken}, 32'd0);
        tick();
        idle();
        #2;
        checkOutput("t2_idle_mispredict", {31'b0, mispredict}, 32'd0);
        checkOutput("t2_bypass_pred", {31'b0, pred_taken}, 32'd1);
        checkOutput("t2_branch_cnt", 32'(branch_cnt), 32'd1);
        checkOutput("t2_mispred_cnt", 32'(mispred_cnt), 32'd1);
        tick();
        checkOutput("t2_table_pred", {31'b0, pred_taken}, 32'd1);

        // 3: three taken resolutions back to back, then two not-taken to prove saturation at 11
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3004, 1'b1, 1'b1);
            #2;
            checkOutput($sformatf("t3_taken%0d_mispredict", i), {31'b0, mispredict}, 32'd0);
            checkOutput($sformatf("t3_taken%0d_pred", i), {31'b0, pred_taken}, 32'd1);
            tick();
        end
        idle();
        #2;
        checkOutput("t3_bypass_pred", {31'b0, pred_taken}, 32'd1);
        checkOutput("t3_branch_cnt", 32'(branch_cnt), 32'd4);
        checkOutput("t3_mispred_cnt", 32'(mispred_cnt), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3004, 1'b1, 1'b0);
        #2;
        checkOutput("t3_nt1_mispredict", {31'b0, mispredict}, 32'd1);
        tick();
        idle();
        #2;
        checkOutput("t3_nt1_pred", {31'b0, pred_taken}, 32'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3004, 1'b1, 1'b0);
        tick();
        idle();
        #2;
        checkOutput("t3_nt2_pred", {31'b0, pred_taken}, 32'd0);
        checkOutput("t3_branch_cnt2", 32'(branch_cnt), 32'd6);
        checkOutput("t3_mispred_cnt2", 32'(mispred_cnt), 32'd3);
        tick();

        // 4: stalled branch resolves once when the stall drops
        if_pc = 32'h0000_3008;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_3008, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #2;
            checkOutput($sformatf("t4_stall%0d_mispredict", i), {31'b0, mispredict}, 32'd0);
            tick();
        end
        checkOutput("t4_stall_branch_cnt", 32'(branch_cnt), 32'd6);
        checkOutput("t4_stall_mispred_cnt", 32'(mispred_cnt), 32'd3);
        checkOutput("t4_stall_pred", {31'b0, pred_taken}, 32'd0);
        id_stall = 1'b0;
        #2;
        checkOutput("t4_release_mispredict", {31'b0, mispredict}, 32'd1);
        tick();
        idle();
        #2;
        checkOutput("t4_bypass_pred", {31'b0, pred_taken}, 32'd1);
        checkOutput("t4_branch_cnt", 32'(branch_cnt), 32'd7);
        checkOutput("t4_mispred_cnt", 32'(mispred_cnt), 32'd4);
        tick();
        checkOutput("t4_once_branch_cnt", 32'(branch_cnt), 32'd7);
        checkOutput("t4_once_mispred_cnt", 32'(mispred_cnt), 32'd4);

        // 5: drive mispred_cnt to all-ones, then one more, then clear with a resolution
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3020, 1'b0, 1'b1);
        for (int i = 0; i < 251; i++)
            tick();
        checkOutput("t5_sat_mispred_cnt", 32'(mispred_cnt), 32'hFF);
        checkOutput("t5_sat_branch_cnt", 32'(branch_cnt), 32'hFF);
        tick();
        checkOutput("t5_hold_mispred_cnt", 32'(mispred_cnt), 32'hFF);
        checkOutput("t5_hold_branch_cnt", 32'(branch_cnt), 32'hFF);
        clr_stats = 1'b1;
        #2;
        checkOutput("t5_clr_mispredict", {31'b0, mispredict}, 32'd1);
        tick();
        clr_stats = 1'b0;
        checkOutput("t5_clr_branch_cnt", 32'(branch_cnt), 32'd0);
        checkOutput("t5_clr_mispred_cnt", 32'(mispred_cnt), 32'd0);
        tick();
        idle();
        checkOutput("t5_after_branch_cnt", 32'(branch_cnt), 32'd1);
        checkOutput("t5_after_mispred_cnt", 32'(mispred_cnt), 32'd1);
        tick();

        // 6: reset drops right after a taken resolution to 0x3010 is latched
        if_pc = 32'h0000_3010;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3010, 1'b1, 1'b1);
        tick();
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3010, 1'b0, 1'b1);
        #2;
        checkOutput("t6_rst_mispredict", {31'b0, mispredict}, 32'd0);
        checkOutput("t6_rst_branch_cnt", 32'(branch_cnt), 32'd0);
        checkOutput("t6_rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
        checkOutput("t6_rst_pred", {31'b0, pred_taken}, 32'd0);
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        checkOutput("t6_entry4_pred", {31'b0, pred_taken}, 32'd0);
        checkOutput("t6_branch_cnt", 32'(branch_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
